// File: rtl/au_add_pipe.sv
// au_add_pipe: pipelined WIDTH-bit adder with carry-in and carry-out.
// The operands are split into STAGES chunks, and one chunk is added per cycle.
// The carry is registered between chunks.
// Each chunk uses a parallel-prefix adder:
//   ARCH=0 Kogge-Stone, ARCH=1 Sklansky, ARCH=2 Brent-Kung.
// The pipeline has a global advance enable with valid/ready on both sides.
// Optional macro AU_ADD_PIPE_OVF_EN adds a registered signed-overflow output, ovf.
module au_add_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int ARCH   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] s,
  output logic             co
`ifdef AU_ADD_PIPE_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int ST     = (STAGES < 1) ? 1 : STAGES;
  localparam int CW     = (WIDTH + ST - 1) / ST;
  localparam int BK_TOP = (CW > 1) ? (1 << ($clog2(CW) - 1)) : 1;

  if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || ARCH < 0 || ARCH > 2) begin : g_bad_param
    $error("au_add_pipe: illegal parameters WIDTH=%0d STAGES=%0d ARCH=%0d", WIDTH, STAGES, ARCH);
  end

  // Returns {carry_out, sum} for the low n bits of x+y+cin.
  // Bits at or above n are forced to generate=propagate=0.
  // cin is folded into bit 0's generate, so each prefix group is a final carry.
  function automatic logic [CW:0] pfx_add(input logic [CW-1:0] x, input logic [CW-1:0] y,
                                          input logic cin, input int n);
    logic [CW-1:0] p, g, pp, gg, sum;
    int j;
    p = x ^ y;
    g = x & y;
    for (int i = 0; i < CW; i++) begin
      if (i >= n) begin
        p[i] = 1'b0;
        g[i] = 1'b0;
      end
    end
    pp = p;
    gg = g;
    gg[0] = g[0] | (p[0] & cin);
    case (ARCH)
      1: begin
        for (int l = 0; (1 << l) < CW; l++) begin
          for (int i = 0; i < CW; i++) begin
            if (((i >> l) & 1) == 1) begin
              j = ((i >> l) << l) - 1;
              gg[i] = gg[i] | (pp[i] & gg[j]);
              pp[i] = pp[i] & pp[j];
            end
          end
        end
      end
      2: begin
        for (int d = 1; d < CW; d *= 2) begin
          for (int i = 2 * d - 1; i < CW; i += 2 * d) begin
            gg[i] = gg[i] | (pp[i] & gg[i-d]);
            pp[i] = pp[i] & pp[i-d];
          end
        end
        for (int d = BK_TOP; d >= 1; d = d / 2) begin
          for (int i = 3 * d - 1; i < CW; i += 2 * d) begin
            gg[i] = gg[i] | (pp[i] & gg[i-d]);
            pp[i] = pp[i] & pp[i-d];
          end
        end
      end
      default: begin
        for (int d = 1; d < CW; d *= 2) begin
          for (int i = CW - 1; i >= d; i--) begin
            gg[i] = gg[i] | (pp[i] & gg[i-d]);
            pp[i] = pp[i] & pp[i-d];
          end
        end
      end
    endcase
    sum[0] = p[0] ^ cin;
    for (int i = 1; i < CW; i++) sum[i] = p[i] ^ gg[i-1];
    if (n == 0) return {cin, sum};
    return {gg[n-1], sum};
  endfunction

  logic [WIDTH-1:0] a_q [ST];
  logic [WIDTH-1:0] b_q [ST];
  logic [WIDTH-1:0] s_q [ST];
  logic             c_q [ST];
  logic             v_q [ST];
  logic [WIDTH-1:0] a_d [ST];
  logic [WIDTH-1:0] b_d [ST];
  logic [WIDTH-1:0] s_d [ST];
  logic             c_d [ST];
  logic             adv;

  assign out_vld = v_q[ST-1];
  assign s       = s_q[ST-1];
  assign co      = c_q[ST-1];
  assign adv     = ~out_vld | out_rdy;
  assign in_rdy  = adv;

`ifdef AU_ADD_PIPE_OVF_EN
  logic ovf_d;
  logic ovf_q;
  assign ovf = ovf_q;
`endif

  // Per-stage chunk add.
  // Each stage takes the previous stage's registers, or the ports for stage 0.
  always_comb begin
    logic [WIDTH-1:0] a_src, b_src, s_src;
    logic             c_src;
    logic [CW-1:0]    xa, ya;
    logic [CW:0]      r;
    int               lo, n;
    a_src = '0;
    b_src = '0;
    s_src = '0;
    c_src = 1'b0;
    xa    = '0;
    ya    = '0;
    r     = '0;
    lo    = 0;
    n     = 0;
`ifdef AU_ADD_PIPE_OVF_EN
    ovf_d = 1'b0;
`endif
    for (int k = 0; k < ST; k++) begin
      if (k == 0) begin
        a_src = a;
        b_src = b;
        s_src = '0;
        c_src = ci;
      end else begin
        a_src = a_q[k-1];
        b_src = b_q[k-1];
        s_src = s_q[k-1];
        c_src = c_q[k-1];
      end
      lo = k * CW;
      n  = (lo >= WIDTH) ? 0 : (((WIDTH - lo) < CW) ? (WIDTH - lo) : CW);
      xa = CW'(a_src >> lo);
      ya = CW'(b_src >> lo);
      r  = pfx_add(xa, ya, c_src, n);
      s_d[k] = s_src;
      for (int j = 0; j < CW; j++) begin
        if (j < n) s_d[k][lo+j] = r[j];
      end
      c_d[k] = r[CW];
      a_d[k] = a_src;
      b_d[k] = b_src;
`ifdef AU_ADD_PIPE_OVF_EN
      // The MSB sum bit is final by the last stage.
      // Carry into the MSB is recovered as a^b^s at that bit.
      if (k == ST - 1) ovf_d = a_src[WIDTH-1] ^ b_src[WIDTH-1] ^ s_d[k][WIDTH-1] ^ c_d[k];
`endif
    end
  end

  // Valid, sum and carry registers: cleared on reset, shifted together on advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < ST; k++) begin
        v_q[k] <= 1'b0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
      end
    end else if (adv) begin
      for (int k = 0; k < ST; k++) begin
        if (k == 0) v_q[k] <= in_vld;
        else        v_q[k] <= v_q[k-1];
        s_q[k] <= s_d[k];
        c_q[k] <= c_d[k];
      end
    end
  end

  // Operand skew registers.
  // They need no reset because nothing reads them through a valid stage after reset.
  always_ff @(posedge clk) begin
    if (adv) begin
      for (int k = 0; k < ST; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
      end
    end
  end

`ifdef AU_ADD_PIPE_OVF_EN
  // Overflow flag, registered alongside the last stage.
  always_ff @(posedge clk) begin
    if (rst)      ovf_q <= 1'b0;
    else if (adv) ovf_q <= ovf_d;
  end
`endif

endmodule

// File: tb/tb_au_add_pipe.sv
// Testbench for au_add_pipe.
// It runs four configurations in parallel: (8,2,0) (13,1,0) (13,4,1) (13,13,2).
// Each configuration has directed vectors, then random traffic with stalls and resets.
// The reference is a stage-occupancy model whose results come from plain a+b+ci arithmetic.
// Define AU_ADD_PIPE_OVF_EN to also check ovf.
module tb_au_add_pipe;

  localparam int NC = 4;
  localparam int CFG_W [NC] = '{8, 13, 13, 13};
  localparam int CFG_S [NC] = '{2, 1, 4, 13};
  localparam int CFG_A [NC] = '{0, 0, 1, 2};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int n_done  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  for (genvar gi = 0; gi < NC; gi++) begin : g_cfg
    localparam int W = CFG_W[gi];
    localparam int S = CFG_S[gi];
    localparam int A = CFG_A[gi];

    logic         rst, in_vld, in_rdy, ci, out_vld, out_rdy, co;
    logic [W-1:0] a, b, s;
`ifdef AU_ADD_PIPE_OVF_EN
    logic         ovf;
`endif

    au_add_pipe #(.WIDTH(W), .STAGES(S), .ARCH(A)) dut (
      .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy),
      .a(a), .b(b), .ci(ci), .out_vld(out_vld), .out_rdy(out_rdy),
      .s(s), .co(co)
`ifdef AU_ADD_PIPE_OVF_EN
      , .ovf(ovf)
`endif
    );

    logic [31:0] m_res [S];
    bit          m_v   [S];
    bit          m_ovf [S];
    bit          known    = 0;
    bit          rst_prev = 0;
    int          stall_left = 0;

    // One cycle:
    //   drive the inputs at the falling edge,
    //   check the outputs 1ns later,
    //   then advance the model as the rising edge will.
    task automatic step(input bit r, input bit iv, input logic [31:0] aa, input logic [31:0] bb,
                        input bit cc, input bit ordy, output bit acc);
      bit          ev, adv, cmsb;
      logic [31:0] mw, hm, sum;
      @(negedge clk);
      rst     = r;
      in_vld  = iv;
      a       = aa[W-1:0];
      b       = bb[W-1:0];
      ci      = cc;
      out_rdy = ordy;
      #1;
      ev  = m_v[S-1];
      adv = !ev || ordy;
      acc = !r && iv && adv;
      if (known) begin
        chk($sformatf("c%0d in_rdy", gi), 32'(in_rdy), 32'(adv));
        chk($sformatf("c%0d out_vld", gi), 32'(out_vld), 32'(ev));
        if (ev) begin
          chk($sformatf("c%0d sum_co", gi), 32'({co, s}), m_res[S-1]);
`ifdef AU_ADD_PIPE_OVF_EN
          chk($sformatf("c%0d ovf", gi), 32'(ovf), 32'(m_ovf[S-1]));
`endif
        end
        if (rst_prev) begin
          chk($sformatf("c%0d rst_sum_co", gi), 32'({co, s}), 32'd0);
`ifdef AU_ADD_PIPE_OVF_EN
          chk($sformatf("c%0d rst_ovf", gi), 32'(ovf), 32'd0);
`endif
        end
      end
      if (r) begin
        for (int k = 0; k < S; k++) m_v[k] = 0;
        known = 1;
      end else if (adv) begin
        for (int k = S - 1; k > 0; k--) begin
          m_v[k]   = m_v[k-1];
          m_res[k] = m_res[k-1];
          m_ovf[k] = m_ovf[k-1];
        end
        mw   = (32'd1 << W) - 1;
        hm   = (32'd1 << (W - 1)) - 1;
        sum  = (aa & mw) + (bb & mw) + 32'(cc);
        cmsb = ((((aa & hm) + (bb & hm) + 32'(cc)) >> (W - 1)) & 1) != 0;
        m_v[0]   = iv;
        m_res[0] = sum;
        m_ovf[0] = cmsb ^ sum[W];
      end
      rst_prev = r;
    endtask

    task automatic send(input logic [31:0] aa, input logic [31:0] bb, input bit cc);
      bit acc, ordy;
      int tries;
      tries = 0;
      do begin
        ordy = (stall_left == 0);
        if (stall_left > 0) stall_left--;
        step(0, 1, aa, bb, cc, ordy, acc);
        tries++;
      end while (!acc && tries < 50);
      if (!acc) chk($sformatf("c%0d send_timeout", gi), 32'd0, 32'd1);
    endtask

    task automatic idle(input int cycles);
      bit acc, ordy;
      for (int i = 0; i < cycles; i++) begin
        ordy = (stall_left == 0);
        if (stall_left > 0) stall_left--;
        step(0, 0, $urandom, $urandom, 0, ordy, acc);
      end
    endtask

    initial begin
      bit acc, ordy, r;
      rst = 1; in_vld = 0; a = '0; b = '0; ci = 0; out_rdy = 0;
      step(1, 0, 0, 0, 0, 1, acc);
      step(1, 1, 5, 6, 0, 1, acc);
      // carry across a chunk boundary
      send(32'hFF, 32'h01, 0);
      idle(S + 1);
      // back-to-back stream
      send(10, 20, 0); send(255, 255, 1); send(128, 128, 0);
      idle(S + 1);
      // three-cycle output stall mid-stream
      send(1, 2, 0); send(3, 4, 1);
      stall_left = 3;
      send(100, 27, 1); send(200, 60, 0);
      idle(S + 4);
      // reset with operands in flight, operands presented during reset
      send(7, 9, 0); send(11, 13, 1);
      step(1, 1, 1, 1, 0, 1, acc);
      idle(S + 2);
      // signed overflow vectors
      send(32'h7F, 32'h01, 0); send(32'h80, 32'hFF, 0); send(32'h05, 32'hFB, 0);
      idle(S + 1);
      // random traffic with random valid, ready and rare resets
      repeat (2500) begin
        ordy = ($urandom_range(0, 3) != 0);
        r    = ($urandom_range(0, 299) == 0);
        step(r, 1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)), ordy, acc);
      end
      idle(S + 2);
      n_done++;
    end
  end

  initial begin
    int cyc;
    cyc = 0;
    while (n_done < NC && cyc < 60000) begin
      @(posedge clk);
      cyc++;
    end
    if (n_done < NC) chk("timeout_done", 32'(n_done), 32'(NC));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
